// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header,
// payload and trailing parity byte to the router while honouring busy.
module router_pkt_tx #(
  parameter int IFG   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       dest_addr,
  input  logic [5:0]       pay_len,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic             busy,
  output logic [7:0]       data_out,
  output logic             pkt_valid,
  output logic             tx_ready,
  output logic             done,
  output logic             cmd_err,
  output logic [CNT_W-1:0] pkt_cnt
);

  // Handshakes: a payload byte moves on an edge with pl_valid & pl_ready;
  // a router byte on data_out moves on an edge with busy=0.
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

  state_t          state, state_nxt;
  logic [1:0]      addr_q;
  logic [5:0]      len_q;
  logic [5:0]      wr_idx;
  logic [5:0]      rd_idx;
  logic [5:0]      rem;
  logic [7:0]      parity;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      mem [0:62];

  logic cmd_ok, wr_fire, last_wr, gap_last;

  assign cmd_ok   = start && (dest_addr != 2'd3) && (pay_len != 6'd0);
  assign wr_fire  = pl_valid && pl_ready;
  assign last_wr  = wr_fire && (wr_idx == len_q - 6'd1);
  assign gap_last = (gap_cnt == GW'(IFG - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_ok) state_nxt = LOAD;
      LOAD:    if (last_wr) state_nxt = HEADER;
      HEADER:  if (!busy) state_nxt = PAYLOAD;
      PAYLOAD: if (!busy && rem == 6'd1) state_nxt = PARITY;
      PARITY:  if (!busy) state_nxt = GAP;
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pl_ready = (state == LOAD);
    tx_ready = (state == IDLE);
  end

  // Payload buffer carries no reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (resetn && wr_fire) mem[wr_idx] <= pl_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q    <= '0;
      len_q     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      rem       <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_err <= start && !cmd_ok;
          if (cmd_ok) begin
            addr_q <= dest_addr;
            len_q  <= pay_len;
            wr_idx <= '0;
          end
        end
        LOAD: begin
          if (wr_fire) wr_idx <= wr_idx + 6'd1;
          if (last_wr) begin
            data_out  <= {len_q, addr_q};
            pkt_valid <= 1'b1;
            parity    <= {len_q, addr_q};
            rd_idx    <= '0;
          end
        end
        HEADER: begin
          if (!busy) begin
            data_out <= mem[rd_idx];
            rd_idx   <= rd_idx + 6'd1;
            rem      <= len_q;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            parity <= parity ^ data_out;
            if (rem == 6'd1) begin
              data_out  <= parity ^ data_out;
              pkt_valid <= 1'b0;
            end else begin
              data_out <= mem[rd_idx];
              rd_idx   <= rd_idx + 6'd1;
              rem      <= rem - 6'd1;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            data_out <= '0;
            gap_cnt  <= '0;
          end
        end
        GAP: begin
          if (gap_last) begin
            done    <= 1'b1;
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: hand-computed byte sequences, parity,
// command rejection, mid-packet reset and counter wrap.
module tb_router_pkt_tx;

  logic        clk = 1'b0;
  logic        resetn, start, pl_valid, busy;
  logic [1:0]  dest_addr;
  logic [5:0]  pay_len;
  logic [7:0]  pl_data;
  logic        pl_ready, pkt_valid, tx_ready, done, cmd_err;
  logic [7:0]  data_out;
  logic [15:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  router_pkt_tx #(.IFG(2), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .dest_addr(dest_addr),
    .pay_len(pay_len), .pl_data(pl_data), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .busy(busy), .data_out(data_out),
    .pkt_valid(pkt_valid), .tx_ready(tx_ready), .done(done),
    .cmd_err(cmd_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic v);
    check({tag, "_data"}, {8'h00, data_out}, {8'h00, d});
    check({tag, "_valid"}, {15'd0, pkt_valid}, {15'd0, v});
    tick();
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    start = 1'b1; dest_addr = a; pay_len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    pl_valid = 1'b1; pl_data = b;
    tick();
    pl_valid = 1'b0;
  endtask

  // Two gap cycles with idle line, then done with the new count, then done low.
  task automatic expect_tail(input string tag, input logic [15:0] cnt);
    check({tag, "_gap1"}, {8'h00, data_out}, 16'h0000);
    check({tag, "_gap1_done"}, {15'd0, done}, 16'd0);
    tick();
    check({tag, "_gap2_done"}, {15'd0, done}, 16'd0);
    tick();
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_cnt"}, pkt_cnt, cnt);
    check({tag, "_txrdy"}, {15'd0, tx_ready}, 16'd1);
    tick();
    check({tag, "_done_low"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; dest_addr = '0; pay_len = '0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
    tick(); tick();
    check("rst_data", {8'h00, data_out}, 16'h0000);
    check("rst_valid", {15'd0, pkt_valid}, 16'd0);
    check("rst_plrdy", {15'd0, pl_ready}, 16'd0);
    check("rst_txrdy", {15'd0, tx_ready}, 16'd1);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_cmderr", {15'd0, cmd_err}, 16'd0);
    check("rst_cnt", pkt_cnt, 16'h0000);
    resetn = 1'b1;
    tick();

    // Basic packet: addr 1, len 3.
    send_cmd(2'd1, 6'd3);
    check("t1_plrdy", {15'd0, pl_ready}, 16'd1);
    check("t1_txrdy", {15'd0, tx_ready}, 16'd0);
    load_byte(8'hA5); load_byte(8'h3C); load_byte(8'h0F);
    expect_byte("t1_hdr", 8'h0D, 1'b1);
    expect_byte("t1_p0", 8'hA5, 1'b1);
    expect_byte("t1_p1", 8'h3C, 1'b1);
    expect_byte("t1_p2", 8'h0F, 1'b1);
    expect_byte("t1_par", 8'h9B, 1'b0);
    expect_tail("t1", 16'd1);

    // Same packet with a 3-cycle stall on the second payload byte.
    send_cmd(2'd1, 6'd3);
    load_byte(8'hA5); load_byte(8'h3C); load_byte(8'h0F);
    expect_byte("t2_hdr", 8'h0D, 1'b1);
    expect_byte("t2_p0", 8'hA5, 1'b1);
    busy = 1'b1;
    expect_byte("t2_hold0", 8'h3C, 1'b1);
    expect_byte("t2_hold1", 8'h3C, 1'b1);
    expect_byte("t2_hold2", 8'h3C, 1'b1);
    busy = 1'b0;
    expect_byte("t2_hold3", 8'h3C, 1'b1);
    expect_byte("t2_p2", 8'h0F, 1'b1);
    expect_byte("t2_par", 8'h9B, 1'b0);
    expect_tail("t2", 16'd2);

    // Rejected commands.
    send_cmd(2'd3, 6'd5);
    check("t3a_cmderr", {15'd0, cmd_err}, 16'd1);
    check("t3a_plrdy", {15'd0, pl_ready}, 16'd0);
    check("t3a_txrdy", {15'd0, tx_ready}, 16'd1);
    tick();
    check("t3a_cmderr_low", {15'd0, cmd_err}, 16'd0);
    check("t3a_plrdy2", {15'd0, pl_ready}, 16'd0);
    send_cmd(2'd0, 6'd0);
    check("t3b_cmderr", {15'd0, cmd_err}, 16'd1);
    check("t3b_plrdy", {15'd0, pl_ready}, 16'd0);
    check("t3b_txrdy", {15'd0, tx_ready}, 16'd1);
    tick();
    check("t3b_cmderr_low", {15'd0, cmd_err}, 16'd0);

    // Maximum length with pl_valid toggling; XOR of 00..3E is 3F, parity FE^3F=C1.
    send_cmd(2'd2, 6'd63);
    for (int i = 0; i < 63; i++) begin
      load_byte(i[7:0]);
      if (i < 62) tick();
    end
    expect_byte("t4_hdr", 8'hFE, 1'b1);
    for (int i = 0; i < 63; i++) expect_byte($sformatf("t4_p%0d", i), i[7:0], 1'b1);
    expect_byte("t4_par", 8'hC1, 1'b0);
    expect_tail("t4", 16'd3);

    // Reset during payload of a len=10 packet (header 28).
    send_cmd(2'd0, 6'd10);
    for (int i = 0; i < 10; i++) load_byte(8'(i * 16 + 3));
    expect_byte("t5_hdr", 8'h28, 1'b1);
    expect_byte("t5_p0", 8'h03, 1'b1);
    expect_byte("t5_p1", 8'h13, 1'b1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t5_rst_valid", {15'd0, pkt_valid}, 16'd0);
    check("t5_rst_data", {8'h00, data_out}, 16'h0000);
    check("t5_rst_txrdy", {15'd0, tx_ready}, 16'd1);
    check("t5_rst_done", {15'd0, done}, 16'd0);
    check("t5_rst_cnt", pkt_cnt, 16'h0000);
    tick();
    check("t5_rst_done2", {15'd0, done}, 16'd0);
    send_cmd(2'd0, 6'd2);
    load_byte(8'h11); load_byte(8'h22);
    expect_byte("t5n_hdr", 8'h08, 1'b1);
    expect_byte("t5n_p0", 8'h11, 1'b1);
    expect_byte("t5n_p1", 8'h22, 1'b1);
    expect_byte("t5n_par", 8'h3B, 1'b0);
    expect_tail("t5n", 16'd1);

    // Counter wrap from FFFF.
    force dut.pkt_cnt = 16'hFFFF;
    tick();
    release dut.pkt_cnt;
    tick();
    check("t6_preload", pkt_cnt, 16'hFFFF);
    send_cmd(2'd1, 6'd1);
    load_byte(8'h55);
    expect_byte("t6_hdr", 8'h05, 1'b1);
    expect_byte("t6_p0", 8'h55, 1'b1);
    expect_byte("t6_par", 8'h50, 1'b0);
    expect_tail("t6", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
